// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM
// state encodings and default latencies. The controller decode imports
// the same op encodings so both sides agree on mdu_op.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MTHI  = 4'd4,
    OP_MTLO  = 4'd5
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } mdu_state_t;

  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;
  localparam int CNT_W       = 8;

  // True for the ops that launch a timed multiply/divide.
  function automatic logic is_muldiv(input logic [3:0] op);
    logic res;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: res = 1'b1;
      default:                            res = 1'b0;
    endcase
    return res;
  endfunction

  // True for the ops that write HI/LO directly.
  function automatic logic is_move(input logic [3:0] op);
    logic res;
    case (op)
      OP_MTHI, OP_MTLO: res = 1'b1;
      default:          res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mdu_div.sv
// Combinational 32-bit divider for the MDU. Produces quotient (truncated
// toward zero) and remainder (sign of dividend) for signed or unsigned
// operands. The signed 0x80000000 / -1 overflow is pinned to
// quotient 0x80000000, remainder 0. Divide-by-zero yields zeros; the
// caller decides whether such a result is ever committed.
module mdu_div
  import mdu_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_signed,
  output logic [31:0] o_quo,
  output logic [31:0] o_rem
);

  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_uquo;
  logic [31:0] w_urem;
  logic        w_ovf;

  assign w_neg_a = i_signed & i_a[31];
  assign w_neg_b = i_signed & i_b[31];
  assign w_abs_a = w_neg_a ? (32'd0 - i_a) : i_a;
  assign w_abs_b = w_neg_b ? (32'd0 - i_b) : i_b;
  assign w_ovf   = i_signed && (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

  // Unsigned magnitude divide, guarded against a zero divisor.
  always_comb begin
    w_uquo = 32'd0;
    w_urem = 32'd0;
    if (w_abs_b != 32'd0) begin
      w_uquo = w_abs_a / w_abs_b;
      w_urem = w_abs_a % w_abs_b;
    end else begin
      w_uquo = 32'd0;
      w_urem = 32'd0;
    end
  end

  // Restore signs: quotient negative when operand signs differ,
  // remainder follows the dividend.
  always_comb begin
    o_quo = 32'd0;
    o_rem = 32'd0;
    if (w_ovf) begin
      o_quo = 32'h8000_0000;
      o_rem = 32'd0;
    end else begin
      o_quo = (w_neg_a ^ w_neg_b) ? (32'd0 - w_uquo) : w_uquo;
      o_rem = w_neg_a ? (32'd0 - w_urem) : w_urem;
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit with HI/LO registers. A multiply or
// divide computes its 64-bit result at launch, holds it as pending and
// commits it after MUL_LAT or DIV_LAT busy cycles unless cancelled by
// req or reset. MTHI/MTLO write HI/LO directly when idle.
// Optional build macro MDU_DIV0_FAST_EN: a divide by zero completes at
// once without entering DIV (no busy cycles, HI/LO unchanged).
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        mips_rst,
  input  logic        start,
  input  logic        we,
  input  logic [3:0]  mdu_op,
  input  logic        r_sel,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        busy,
  output logic [31:0] R
);

  mdu_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_pend_hi;
  logic [31:0]      r_pend_lo;
  logic             r_pend_ok;
  logic             r_busy;

  mdu_state_t       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [31:0]      w_hi_nxt;
  logic [31:0]      w_lo_nxt;
  logic [31:0]      w_pend_hi_nxt;
  logic [31:0]      w_pend_lo_nxt;
  logic             w_pend_ok_nxt;

  logic [63:0]      w_a_sx;
  logic [63:0]      w_b_sx;
  logic [63:0]      w_mul_s;
  logic [63:0]      w_mul_u;
  logic [31:0]      w_quo;
  logic [31:0]      w_rem;
  logic             w_div_signed;
  logic             w_b_zero;

  // Low 64 bits of the sign-extended product equal the signed product.
  assign w_a_sx       = {{32{A[31]}}, A};
  assign w_b_sx       = {{32{B[31]}}, B};
  assign w_mul_s      = w_a_sx * w_b_sx;
  assign w_mul_u      = {32'd0, A} * {32'd0, B};
  assign w_div_signed = (mdu_op == OP_DIV);
  assign w_b_zero     = (B == 32'd0);

  mdu_div u_div (
    .i_a      (A),
    .i_b      (B),
    .i_signed (w_div_signed),
    .o_quo    (w_quo),
    .o_rem    (w_rem)
  );

  // Next-state, counter, pending and HI/LO update logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    w_pend_hi_nxt = r_pend_hi;
    w_pend_lo_nxt = r_pend_lo;
    w_pend_ok_nxt = r_pend_ok;
    case (r_state)
      IDLE: begin
        if (req) begin
          // Exception in the issue cycle suppresses start and we.
          w_state_nxt = IDLE;
        end else if (start && is_muldiv(mdu_op)) begin
          if ((mdu_op == OP_MULT) || (mdu_op == OP_MULTU)) begin
            w_pend_hi_nxt = (mdu_op == OP_MULT) ? w_mul_s[63:32] : w_mul_u[63:32];
            w_pend_lo_nxt = (mdu_op == OP_MULT) ? w_mul_s[31:0]  : w_mul_u[31:0];
            w_pend_ok_nxt = 1'b1;
            w_cnt_nxt     = CNT_W'(MUL_LAT - 1);
            w_state_nxt   = MUL;
          end else if (w_b_zero) begin
`ifdef MDU_DIV0_FAST_EN
            w_state_nxt   = IDLE;
`else
            // Run the full divide latency but never commit.
            w_pend_hi_nxt = 32'd0;
            w_pend_lo_nxt = 32'd0;
            w_pend_ok_nxt = 1'b0;
            w_cnt_nxt     = CNT_W'(DIV_LAT - 1);
            w_state_nxt   = DIV;
`endif
          end else begin
            w_pend_hi_nxt = w_rem;
            w_pend_lo_nxt = w_quo;
            w_pend_ok_nxt = 1'b1;
            w_cnt_nxt     = CNT_W'(DIV_LAT - 1);
            w_state_nxt   = DIV;
          end
        end else if (we && is_move(mdu_op)) begin
          if (mdu_op == OP_MTHI) begin
            w_hi_nxt = A;
          end else begin
            w_lo_nxt = A;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      MUL, DIV: begin
        if (req) begin
          // Cancel wins even on the final edge: nothing is committed.
          w_pend_hi_nxt = 32'd0;
          w_pend_lo_nxt = 32'd0;
          w_pend_ok_nxt = 1'b0;
          w_cnt_nxt     = {CNT_W{1'b0}};
          w_state_nxt   = IDLE;
        end else if (r_cnt == {CNT_W{1'b0}}) begin
          if (r_pend_ok) begin
            w_hi_nxt = r_pend_hi;
            w_lo_nxt = r_pend_lo;
          end else begin
            w_hi_nxt = r_hi;
            w_lo_nxt = r_lo;
          end
          w_pend_ok_nxt = 1'b0;
          w_state_nxt   = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_pend_ok_nxt = 1'b0;
        w_cnt_nxt     = {CNT_W{1'b0}};
        w_state_nxt   = IDLE;
      end
    endcase
  end

  // State, counter, HI/LO and pending registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!mips_rst) begin
      r_state   <= IDLE;
      r_cnt     <= {CNT_W{1'b0}};
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_ok <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
      r_pend_hi <= w_pend_hi_nxt;
      r_pend_lo <= w_pend_lo_nxt;
      r_pend_ok <= w_pend_ok_nxt;
      r_busy    <= (w_state_nxt != IDLE);
    end
  end

  assign busy = r_busy;
  assign R    = r_sel ? r_hi : r_lo;

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: each issued op pushes its expected busy
// length and HI/LO into a queue; when the unit goes idle the entry is
// popped and compared against busy cycles counted and R.
module tb_mdu_seq;
  import mdu_pkg::*;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic        clk = 1'b0;
  logic        mips_rst = 1'b0;
  logic        start = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  mdu_op = 4'd0;
  logic        r_sel = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        req = 1'b0;
  logic        busy;
  logic [31:0] R;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          checks = 0;
  int          errors = 0;

  mdu_seq #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .mips_rst(mips_rst), .start(start), .we(we), .mdu_op(mdu_op),
    .r_sel(r_sel), .A(A), .B(B), .req(req), .busy(busy), .R(R)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare R with r_sel=1 (HI) and r_sel=0 (LO) against given values.
  task automatic check_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    r_sel = 1'b1; #1;
    check({tag, "_hi"}, {32'd0, R}, {32'd0, hi});
    r_sel = 1'b0; #1;
    check({tag, "_lo"}, {32'd0, R}, {32'd0, lo});
  endtask

  // Issue one op; optional req, in-busy start, or reset on busy cycle N.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit req0, input int cancel_cyc, input int start_cyc,
                       input int rst_cyc);
    exp_t        e;
    longint      sa, sb, q, r;
    logic [63:0] p;
    bit          commit;
    int          cnt;
    e.hi = m_hi; e.lo = m_lo; e.len = 0; commit = 1'b0; p = 64'd0;
    if (!req0) begin
      case (op)
        OP_MULT: begin
          sa = longint'($signed(a)); sb = longint'($signed(b));
          p = 64'(sa * sb); e.len = MUL_LAT; commit = 1'b1;
        end
        OP_MULTU: begin
          p = {32'd0, a} * {32'd0, b}; e.len = MUL_LAT; commit = 1'b1;
        end
        OP_DIV, OP_DIVU: begin
          if (op == OP_DIV) begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
          end else begin
            sa = longint'({32'd0, a}); sb = longint'({32'd0, b});
          end
          if (b == 32'd0) begin
`ifdef MDU_DIV0_FAST_EN
            e.len = 0;
`else
            e.len = DIV_LAT;
`endif
          end else begin
            q = sa / sb; r = sa % sb;
            p = {r[31:0], q[31:0]}; e.len = DIV_LAT; commit = 1'b1;
          end
        end
        OP_MTHI: e.hi = a;
        OP_MTLO: e.lo = a;
        default: e.len = 0;
      endcase
    end
    if (commit) begin
      e.hi = p[63:32]; e.lo = p[31:0];
    end
    if (cancel_cyc > 0) begin
      e.len = cancel_cyc; e.hi = m_hi; e.lo = m_lo;
    end
    if (rst_cyc > 0) begin
      e.len = rst_cyc; e.hi = 32'd0; e.lo = 32'd0;
    end
    m_hi = e.hi; m_lo = e.lo;
    sb_q.push_back(e);

    @(negedge clk);
    mdu_op = op; A = a; B = b; req = req0;
    if ((op == OP_MTHI) || (op == OP_MTLO)) we = 1'b1;
    else start = 1'b1;
    @(negedge clk);
    start = 1'b0; we = 1'b0; req = 1'b0;
    cnt = 0;
    while (busy && (cnt < 100)) begin
      cnt++;
      req = (cnt == cancel_cyc);
      mips_rst = !(cnt == rst_cyc);
      if (cnt == start_cyc) begin
        start = 1'b1; mdu_op = OP_DIVU; A = 32'd1000; B = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    req = 1'b0; start = 1'b0; mips_rst = 1'b1;
    check("timeout", {63'd0, busy}, 64'd0);
    e = sb_q.pop_front();
    check("busy_len", 64'(cnt), 64'(e.len));
    check_hilo("result", e.hi, e.lo);
    repeat (3) @(negedge clk);
    check("idle_busy", {63'd0, busy}, 64'd0);
    check_hilo("hold", e.hi, e.lo);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check_hilo("rst", 32'd0, 32'd0);
    mips_rst = 1'b1;

    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 0, 0, 0);
    check_hilo("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, 0, 0);
    check_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(OP_DIVU, 32'd7, 32'd2, 1'b0, 0, 0, 0);
    check_hilo("divu", 32'd1, 32'd3);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 0, 0);
    check_hilo("div_ovf", 32'd0, 32'h8000_0000);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0, 0);
    check_hilo("multu_max", 32'hFFFF_FFFE, 32'd1);

    issue(OP_MTHI, 32'hAAAA_5555, 32'd0, 1'b0, 0, 0, 0);
    issue(OP_MTLO, 32'h0000_1234, 32'd0, 1'b0, 0, 0, 0);
    issue(OP_DIV, 32'd5, 32'd0, 1'b0, 0, 0, 0);
    check_hilo("div0", 32'hAAAA_5555, 32'h0000_1234);
    issue(OP_DIVU, 32'd9, 32'd0, 1'b0, 0, 0, 0);

    issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b0, 3, 0, 0);
    check_hilo("cancel", 32'hAAAA_5555, 32'h0000_1234);
    issue(OP_MULT, 32'd12, 32'hFFFF_FFFD, 1'b0, 0, 2, 0);
    issue(OP_DIVU, 32'd100, 32'd7, 1'b0, DIV_LAT, 0, 0);
    issue(OP_MULT, 32'd9, 32'd9, 1'b1, 0, 0, 0);
    issue(OP_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b1, 0, 0, 0);
    issue(OP_MULT, 32'd4, 32'd4, 1'b0, MUL_LAT, 0, 0);

    issue(OP_DIV, 32'd100, 32'd7, 1'b0, 0, 0, 4);
    check_hilo("reset_mid", 32'd0, 32'd0);
    issue(OP_MULT, 32'd2, 32'd3, 1'b0, 0, 0, 0);
    check_hilo("after_rst", 32'd0, 32'd6);

    for (int i = 0; i < 6; i++) begin
      issue(OP_MULT + 4'(i % 4), $urandom, $urandom_range(1, 32'h7FFF_FFFF) ^
            ((i % 2 == 1) ? 32'hFFFF_0000 : 32'd0), 1'b0, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock.
REQ-002 SHALL have port mips_rst, input, 1, synchronous active-low reset.
REQ-003 SHALL have port start, input, 1, launch multiply/divide when mdu_op is MULT/MULTU/DIV/DIVU.
REQ-004 SHALL have port we, input, 1, write HI or LO directly when mdu_op is MTHI/MTLO.
REQ-005 SHALL have port mdu_op, input, 4, operation code (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
REQ-006 SHALL have port r_sel, input, 1, R source (0 = LO, 1 = HI).
REQ-007 SHALL have port A, input, 32, operand rs.
REQ-008 SHALL have port B, input, 32, operand rt.
REQ-009 SHALL have port req, input, 1, exception request that cancels in-flight work.
REQ-010 SHALL have port busy, output, 1, operation in progress; the hazard unit stalls MDU instructions on it.
REQ-011 SHALL have port R, output, 32, the HI or LO value selected by r_sel.
REQ-012 SHALL have parameter MUL_LAT, default 5, busy cycles for MULT/MULTU.
REQ-013 SHALL have parameter DIV_LAT, default 10, busy cycles for DIV/DIVU.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DIV.
REQ-015 SHALL, in IDLE with start=1, req=0 and a valid op, compute the 64-bit result from A/B and latch it into pending registers.
REQ-016 SHALL, in the same case, load the counter with MUL_LAT-1 or DIV_LAT-1 and enter MUL or DIV.
REQ-017 SHALL assert busy from the cycle after start for exactly MUL_LAT or DIV_LAT cycles.
REQ-018 SHALL decrement the counter each busy cycle; at count 0, commit pending HI/LO on that edge and return to IDLE.
REQ-019 SHALL make the committed HI/LO visible on R in the first cycle busy=0.
REQ-020 SHALL compute MULT as signed 64-bit A*B and MULTU as unsigned; HI=[63:32], LO=[31:0].
REQ-021 SHALL compute DIV with the quotient truncated toward zero and the remainder taking the dividend's sign; LO=quotient, HI=remainder.
REQ-022 SHALL compute DIVU as unsigned.
REQ-023 SHALL return LO=0x80000000, HI=0 for DIV of 0x80000000 by 0xFFFFFFFF.
REQ-024 SHALL leave HI/LO unchanged on divide-by-zero, which still runs DIV_LAT busy cycles unless REQ-033 applies.
REQ-025 SHALL ignore start and we while busy=1; issuing these is an upstream error and is not flagged.
REQ-026 SHALL, with we=1, req=0 and busy=0, write A to HI (MTHI) or LO (MTLO) on that edge.
REQ-027 SHALL, when req=1 in MUL/DIV, discard the pending result, leave HI/LO untouched, go to IDLE, and drop busy next cycle.
REQ-028 SHALL, when req=1 in the same cycle as start or we, suppress both.
REQ-029 SHALL, when req=1 on the same edge the counter reaches 0, cancel the operation with no commit.
REQ-030 SHALL make R purely combinational from HI/LO, with no dependence on state.

Reset
REQ-031 SHALL, when mips_rst=0 at a clock edge, set state=IDLE, counter=0, HI=0, LO=0, pending=0 and busy=0, overriding all other inputs.
REQ-032 SHALL, on reset asserted mid-operation, abort with no commit; R=0 in the following cycle.

Configuration
REQ-033 SHALL, when MDU_DIV0_FAST_EN is defined, complete a DIV/DIVU with B=0 without entering DIV: busy stays 0 and HI/LO stay unchanged.
REQ-034 SHALL, when MDU_DIV0_FAST_EN is undefined, handle B=0 per REQ-024.

Structure
REQ-035 SHALL place the mdu_op encodings, FSM state encodings and default MUL_LAT/DIV_LAT constants in shared package mdu_pkg, also used by the controller decode.
REQ-036 SHALL isolate signed/unsigned quotient and remainder computation, including the REQ-023 corner, in sub-module mdu_div; the multiply stays inline.

Verification
REQ-037 SHALL cover: MULT A=0xFFFFFFFE (-2), B=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-038 SHALL cover: DIV A=-7, B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=2 -> LO=3, HI=1.
REQ-039 SHALL cover: MTLO A=0x1234 then DIV A=5, B=0 -> HI/LO unchanged (LO=0x1234); busy 10 cycles without the macro, 0 cycles with it.
REQ-040 SHALL cover: MULTU 0x10000 x 0x10000 with req=1 on busy cycle 3 -> busy=0 next cycle, prior HI/LO kept, no later commit.
REQ-041 SHALL cover: start during busy, and req coinciding with the count-0 edge -> neither alters HI/LO.
REQ-042 SHALL cover: mips_rst=0 during a DIV -> busy=0, HI=LO=0 after the edge; a new MULT 2x3 afterwards gives LO=6.
